reg8_arbiter: RTL and testbench
===============================

Name: reg8_arbiter

Overview:
- Two-requester round-robin arbiter that owns one shared 8-bit register and grants exclusive write access to it.
- Sits between two producer blocks and the 8-bit storage element. Sequences ownership with a registered req/gnt handshake and a bounded hold time.
- The register value is always readable on q.

Parameters:
- MAX_HOLD, 4: cycles an owner may keep the grant while the other requester is waiting; legal range >= 1.
- RESET_VAL, 8'h00: value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  request per requester; bit i = requester i.
- we  input  2  write enable per requester; honoured only while that requester is granted.
- d0  input  8  write data from requester 0.
- d1  input  8  write data from requester 1.
- gnt  output  2  registered grant, one-hot or 2'b00.
- q  output  8  current register contents.
- busy  output  1  equals |gnt.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, gnt=2'b00, busy=0, q=RESET_VAL, hold_cnt=0.
  - last_owner=1, so requester 0 wins the first contention.
- States: IDLE, OWN0, OWN1. gnt decodes directly from state: OWN0->01, OWN1->10, IDLE->00.
- Grant latency: req[i] sampled high at edge n (state IDLE) -> gnt[i]=1 from edge n onward, i.e. one cycle after req is first presented.
- IDLE transitions:
  - req=01 -> OWN0.
  - req=10 -> OWN1.
  - req=11 -> OWN of the requester != last_owner.
  - req=00 -> stay in IDLE.
- OWNi transitions (j = other requester):
  - req[i]=0 -> OWNj if req[j]=1 (no idle bubble), else IDLE.
  - req[i]=1, req[j]=1 and hold_cnt==MAX_HOLD-1 -> preempt to OWNj.
  - otherwise stay in OWNi.
- hold_cnt:
  - cleared on any state change.
  - in OWNi: increments while req[j]=1; cleared when req[j]=0.
  - never exceeds MAX_HOLD-1.
- last_owner updates to i on every entry into OWNi.
- Write commit:
  - In any cycle with gnt[i]=1, req[i]=1 and we[i]=1 -> q <= d_i at the next edge.
  - This includes the final cycle of a grant (release or preemption).
- Ignored writes: we[i] while gnt[i]=0, or while req[i]=0, is ignored; q holds.
- Only the granted requester can write; simultaneous we=11 commits only the owner's data.
- Reset mid-operation: reset wins over any pending write or transition. The next cycle shows gnt=00 and q=RESET_VAL.
- q is a pure register output: no combinational path from d0/d1 to q.

Optional Feature:
- Macro REG8_ARB_WRCNT_EN.
- Defined:
  - Adds output port wr_cnt (8 bits), counting committed writes (any requester).
  - Saturates at 8'hFF; reset to 8'h00.
  - Increments in the same edge that updates q.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=01, we=01, d0=8'hA5 -> gnt=01 one cycle later; q=8'hA5 the cycle after the grant; busy=1.
- After reset, req=11 simultaneously -> gnt=01 first. With MAX_HOLD=4 and req held at 11, gnt flips to 10 after exactly 4 grant cycles. It flips back to 01 4 cycles later.
- Owner 0 drops req while req[1]=1 -> gnt goes 01 -> 10 on the next edge, with no 00 cycle in between.
- we=10, d1=8'h3C while gnt=01, we[0]=0 -> q unchanged. With we=11, d0=8'h11, d1=8'h22 while gnt=01 -> q=8'h11.
- Assert reset for one cycle during OWN1 with we[1]=1, d1=8'hFF -> next cycle gnt=00, q=RESET_VAL. The next contention is won by requester 0.
- REG8_ARB_WRCNT_EN defined: 300 consecutive committed writes -> wr_cnt=8'hFF (saturated). Reset -> wr_cnt=8'h00.

Source files
------------

// File: rtl/reg8_arbiter.sv
// Two-requester round-robin arbiter guarding one shared 8-bit register, with bounded hold time.
// Define REG8_ARB_WRCNT_EN to add the saturating committed-write counter output wr_cnt.
module reg8_arbiter #(
  parameter int         MAX_HOLD  = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic [1:0] gnt,
  output logic [7:0] q,
  output logic       busy
`ifdef REG8_ARB_WRCNT_EN
  ,
  output logic [7:0] wr_cnt
`endif
);

  localparam int             CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_owner;
  logic [CW-1:0]   r_hold_cnt;
  logic [CW-1:0]   w_hold_next;
  logic            w_wr0;
  logic            w_wr1;
  logic [7:0]      r_q;

  assign gnt  = {r_state == OWN1, r_state == OWN0};
  assign busy = |gnt;
  assign q    = r_q;

  // Only the current owner can commit; gnt is one-hot so at most one of these is set.
  assign w_wr0 = gnt[0] & req[0] & we[0];
  assign w_wr1 = gnt[1] & req[1] & we[1];

  always_comb begin
    w_next      = r_state;
    w_hold_next = r_hold_cnt;
    case (r_state)
      IDLE: begin
        case (req)
          2'b01:   w_next = OWN0;
          2'b10:   w_next = OWN1;
          2'b11:   w_next = r_last_owner ? OWN0 : OWN1;
          default: w_next = IDLE;
        endcase
      end
      OWN0: begin
        if (!req[0]) begin
          w_next = req[1] ? OWN1 : IDLE;
        end else if (req[1]) begin
          if (r_hold_cnt == HOLD_LAST) w_next = OWN1;
          else                         w_hold_next = r_hold_cnt + 1'b1;
        end else begin
          w_hold_next = '0;
        end
      end
      OWN1: begin
        if (!req[1]) begin
          w_next = req[0] ? OWN0 : IDLE;
        end else if (req[0]) begin
          if (r_hold_cnt == HOLD_LAST) w_next = OWN0;
          else                         w_hold_next = r_hold_cnt + 1'b1;
        end else begin
          w_hold_next = '0;
        end
      end
      default: w_next = IDLE;
    endcase
    // Any ownership change restarts the hold window.
    if (w_next != r_state) w_hold_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_last_owner <= 1'b1;
      r_q          <= RESET_VAL;
    end else begin
      r_state    <= w_next;
      r_hold_cnt <= w_hold_next;
      if (w_next == OWN0 && r_state != OWN0) r_last_owner <= 1'b0;
      if (w_next == OWN1 && r_state != OWN1) r_last_owner <= 1'b1;
      if (w_wr0)      r_q <= d0;
      else if (w_wr1) r_q <= d1;
    end
  end

`ifdef REG8_ARB_WRCNT_EN
  logic [7:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt <= 8'h00;
    end else if ((w_wr0 | w_wr1) && r_wr_cnt != 8'hFF) begin
      r_wr_cnt <= r_wr_cnt + 8'h01;
    end
  end

  assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_reg8_arbiter.sv
// Scoreboard bench for reg8_arbiter: a driver pushes reference-model expectations, a monitor pops and compares.
module tb_reg8_arbiter;

  localparam int         MAX_HOLD  = 4;
  localparam logic [7:0] RESET_VAL = 8'h5A;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [1:0] gnt;
  logic [7:0] q;
  logic       busy;
  logic [7:0] wr_cnt_act;

  always #5 clk = ~clk;

  reg8_arbiter #(.MAX_HOLD(MAX_HOLD), .RESET_VAL(RESET_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .d0    (d0),
    .d1    (d1),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy)
`ifdef REG8_ARB_WRCNT_EN
    ,
    .wr_cnt(wr_cnt_act)
`endif
  );

`ifndef REG8_ARB_WRCNT_EN
  assign wr_cnt_act = 8'h00;
`endif

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] q;
    logic       busy;
    logic [7:0] wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: owner -1 means nobody holds the register.
  int   m_owner = -1;
  int   m_last  = 1;
  int   m_held  = 0;
  int   m_q     = 0;
  int   m_wc    = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, expv);
  endtask

  task automatic grant_to(input int who);
    m_owner = who;
    m_last  = who;
    m_held  = 0;
  endtask

  task automatic model_step(input logic rst, input logic [1:0] r, input logic [1:0] w,
                            input logic [7:0] a, input logic [7:0] b);
    int o;
    int j;
    if (rst) begin
      m_owner = -1; m_last = 1; m_held = 0; m_q = int'(RESET_VAL); m_wc = 0;
      return;
    end
    if (m_owner >= 0 && r[m_owner] && w[m_owner]) begin
      m_q  = (m_owner == 1) ? int'(b) : int'(a);
      m_wc = (m_wc < 255) ? m_wc + 1 : 255;
    end
    if (m_owner < 0) begin
      if (r == 2'b11)      grant_to(1 - m_last);
      else if (r == 2'b01) grant_to(0);
      else if (r == 2'b10) grant_to(1);
    end else begin
      o = m_owner;
      j = 1 - o;
      if (!r[o]) begin
        if (r[j]) grant_to(j);
        else begin m_owner = -1; m_held = 0; end
      end else if (r[j]) begin
        m_held++;
        if (m_held >= MAX_HOLD) grant_to(j);
      end else begin
        m_held = 0;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] r, input logic [1:0] w,
                     input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    reset = rst; req = r; we = w; d0 = a; d1 = b;
    model_step(rst, r, w, a, b);
    e.gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e.q    = 8'(m_q);
    e.busy = (m_owner >= 0);
    e.wc   = 8'(m_wc);
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",  {6'd0, gnt},  {6'd0, e.gnt});
        check("q",    q,            e.q);
        check("busy", {7'd0, busy}, {7'd0, e.busy});
`ifdef REG8_ARB_WRCNT_EN
        check("wr_cnt", wr_cnt_act, e.wc);
`endif
      end
    end
  end

  initial begin : driver
    reset = 1'b1; req = 2'b00; we = 2'b00; d0 = 8'h00; d1 = 8'h00;
    // Basic grant and write.
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00);
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b01, 2'b01, 8'hA5, 8'h00);
    cyc(0, 2'b01, 2'b01, 8'hA5, 8'h00);
    cyc(0, 2'b01, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00);
    // Contention with bounded hold, round-robin alternation.
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) cyc(0, 2'b11, 2'b00, 8'h00, 8'h00);
    // Owner 0 releases while 1 waits: no idle bubble.
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b01, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b11, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b10, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b10, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00);
    // Non-owner writes ignored; simultaneous we commits only the owner.
    cyc(0, 2'b01, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b01, 2'b10, 8'h00, 8'h3C);
    cyc(0, 2'b01, 2'b11, 8'h11, 8'h22);
    cyc(0, 2'b01, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00);
    // Reset during OWN1 with a pending write, then fresh contention.
    cyc(0, 2'b10, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b10, 2'b00, 8'h00, 8'h00);
    cyc(1, 2'b10, 2'b10, 8'h00, 8'hFF);
    cyc(0, 2'b11, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b11, 2'b00, 8'h00, 8'h00);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00);
    // Long run of committed writes saturates the counter, then reset clears it.
    for (int i = 0; i < 300; i++) cyc(0, 2'b01, 2'b01, 8'($urandom), 8'h00);
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(0, 63) == 0), 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
